out_port_fifo: RTL and testbench

- Per-destination packet buffer sitting directly downstream of the input-channel FSM.
- Captures the byte stream qualified by one of that FSM's per-port FIFO write enables (`o_pkt_to_fifo_enN`) together with its data output.
- Stores bytes in a circular buffer, tracks packet boundaries from the header byte, and presents them to the output port with a first-word-fall-through read interface.
- Flushes itself if the consumer stalls past a timeout.

---
 rtl/out_port_fifo.sv | 163 ++++++++++++++++
 tb/tb_out_port_fifo.sv | 233 +++++++++++++++++++++++
 2 files changed

// File: rtl/out_port_fifo.sv
// Per-destination packet buffer: circular byte store with header-based packet
// framing, first-word-fall-through read port and a stalled-consumer flush.
module out_port_fifo #(
    parameter int data_size       = 8,
    parameter int pkt_length_bits = 5,
    parameter int fifo_depth      = 16,
    parameter int addr_bits       = 4,
    parameter int timeout_cycles  = 30
) (
    input  logic                 i_clk,
    input  logic                 i_rstn,
    input  logic                 i_wr_en,
    input  logic [data_size-1:0] i_data_in,
    input  logic                 i_rd_en,
    input  logic                 i_clr_errors,
    output logic [data_size-1:0] o_data_out,
    output logic                 o_valid,
    output logic                 o_full,
    output logic                 o_almost_full,
    output logic                 o_pkt_avail,
    output logic [addr_bits:0]   o_count,
    output logic                 o_overflow_err,
    output logic                 o_underflow_err,
    output logic                 o_soft_rst
);

    localparam int stall_bits = $clog2(timeout_cycles + 1);
    localparam logic [addr_bits:0]       cnt_one   = 1;
    localparam logic [addr_bits:0]       cnt_depth = (addr_bits+1)'(fifo_depth);
    localparam logic [pkt_length_bits:0] rem_one   = 1;
    localparam logic [stall_bits-1:0]    stall_one = 1;
    localparam logic [stall_bits-1:0]    stall_hit = stall_bits'(timeout_cycles - 1);

    logic [data_size-1:0]    mem [fifo_depth];
    logic [addr_bits-1:0]    wr_ptr;
    logic [addr_bits-1:0]    rd_ptr;
    logic [addr_bits:0]      count;
    logic [addr_bits:0]      pkt_cnt;
    logic [pkt_length_bits:0] wr_rem;
    logic [pkt_length_bits:0] rd_rem;
    logic [stall_bits-1:0]   stall_cnt;
    logic                    clr_q;
    logic                    overflow_err;
    logic                    underflow_err;
    logic                    soft_rst;

    logic                    full;
    logic                    valid;
    logic                    flush;
    logic                    wr_ok;
    logic                    rd_ok;
    logic                    clr_rise;
    logic                    wr_done;
    logic                    rd_done;
    logic [data_size-1:0]    rd_byte;
    logic [pkt_length_bits:0] wr_hdr_len;
    logic [pkt_length_bits:0] rd_hdr_len;

    assign full       = (count == cnt_depth);
    assign valid      = (count != '0);
    assign rd_byte    = mem[rd_ptr];
    assign flush      = valid && !i_rd_en && (stall_cnt == stall_hit);
    assign wr_ok      = i_wr_en && !full && !flush;
    assign rd_ok      = i_rd_en && valid;
    assign clr_rise   = i_clr_errors && !clr_q;
    assign wr_hdr_len = {1'b0, i_data_in[data_size-1 -: pkt_length_bits]};
    assign rd_hdr_len = {1'b0, rd_byte[data_size-1 -: pkt_length_bits]};

    // Framing advances on every write strobe, even dropped ones, so the write
    // side stays aligned with the upstream byte stream.
    assign wr_done = i_wr_en && ((wr_rem == '0) ? (wr_hdr_len == '0) : (wr_rem == rem_one));
    assign rd_done = rd_ok   && ((rd_rem == '0) ? (rd_hdr_len == '0) : (rd_rem == rem_one));

    always_ff @(posedge i_clk) begin
        if (wr_ok) begin
            mem[wr_ptr] <= i_data_in;
        end
    end

    always_ff @(posedge i_clk or negedge i_rstn) begin
        if (!i_rstn) begin
            wr_ptr        <= '0;
            rd_ptr        <= '0;
            count         <= '0;
            pkt_cnt       <= '0;
            wr_rem        <= '0;
            rd_rem        <= '0;
            stall_cnt     <= '0;
            clr_q         <= 1'b0;
            overflow_err  <= 1'b0;
            underflow_err <= 1'b0;
            soft_rst      <= 1'b0;
        end else begin
            clr_q    <= i_clr_errors;
            soft_rst <= flush;

            if (i_wr_en && full) begin
                overflow_err <= 1'b1;
            end else if (clr_rise) begin
                overflow_err <= 1'b0;
            end

            if (i_rd_en && !valid) begin
                underflow_err <= 1'b1;
            end else if (clr_rise) begin
                underflow_err <= 1'b0;
            end

            if (flush) begin
                wr_ptr    <= '0;
                rd_ptr    <= '0;
                count     <= '0;
                pkt_cnt   <= '0;
                wr_rem    <= '0;
                rd_rem    <= '0;
                stall_cnt <= '0;
            end else begin
                if (wr_ok) begin
                    wr_ptr <= wr_ptr + 1'b1;
                end
                if (rd_ok) begin
                    rd_ptr <= rd_ptr + 1'b1;
                end

                case ({wr_ok, rd_ok})
                    2'b10:   count <= count + cnt_one;
                    2'b01:   count <= count - cnt_one;
                    default: count <= count;
                endcase

                if (i_wr_en) begin
                    wr_rem <= (wr_rem == '0) ? wr_hdr_len : wr_rem - rem_one;
                end
                if (rd_ok) begin
                    rd_rem <= (rd_rem == '0) ? rd_hdr_len : rd_rem - rem_one;
                end

                if (wr_done && !rd_done && pkt_cnt != cnt_depth) begin
                    pkt_cnt <= pkt_cnt + cnt_one;
                end else if (rd_done && !wr_done && pkt_cnt != '0) begin
                    pkt_cnt <= pkt_cnt - cnt_one;
                end

                if (!valid || rd_ok) begin
                    stall_cnt <= '0;
                end else begin
                    stall_cnt <= stall_cnt + stall_one;
                end
            end
        end
    end

    assign o_data_out      = valid ? rd_byte : '0;
    assign o_valid         = valid;
    assign o_full          = full;
    assign o_almost_full   = (count >= (addr_bits+1)'(fifo_depth - 2));
    assign o_pkt_avail     = (pkt_cnt != '0);
    assign o_count         = count;
    assign o_overflow_err  = overflow_err;
    assign o_underflow_err = underflow_err;
    assign o_soft_rst      = soft_rst;

endmodule

// File: tb/tb_out_port_fifo.sv
// Bench for out_port_fifo: directed scenarios plus random traffic, every cycle
// compared against a queue-based reference model of the buffer.
module tb_out_port_fifo;

    logic       i_clk;
    logic       i_rstn;
    logic       i_wr_en;
    logic [7:0] i_data_in;
    logic       i_rd_en;
    logic       i_clr_errors;
    logic [7:0] o_data_out;
    logic       o_valid;
    logic       o_full;
    logic       o_almost_full;
    logic       o_pkt_avail;
    logic [4:0] o_count;
    logic       o_overflow_err;
    logic       o_underflow_err;
    logic       o_soft_rst;

    out_port_fifo dut (
        .i_clk          (i_clk),
        .i_rstn         (i_rstn),
        .i_wr_en        (i_wr_en),
        .i_data_in      (i_data_in),
        .i_rd_en        (i_rd_en),
        .i_clr_errors   (i_clr_errors),
        .o_data_out     (o_data_out),
        .o_valid        (o_valid),
        .o_full         (o_full),
        .o_almost_full  (o_almost_full),
        .o_pkt_avail    (o_pkt_avail),
        .o_count        (o_count),
        .o_overflow_err (o_overflow_err),
        .o_underflow_err(o_underflow_err),
        .o_soft_rst     (o_soft_rst)
    );

    initial i_clk = 1'b0;
    always #5 i_clk = ~i_clk;

    int n_checks = 0;
    int n_errors = 0;

    // Reference model state
    logic [7:0] mq[$];
    int  m_wr_left, m_rd_left, m_pkts, m_stall;
    bit  m_ovf, m_udf, m_clr_q, m_soft;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic model_reset();
        mq.delete();
        m_wr_left = 0; m_rd_left = 0; m_pkts = 0; m_stall = 0;
        m_ovf = 0; m_udf = 0; m_clr_q = 0; m_soft = 0;
    endtask

    task automatic check_outputs();
        int n;
        n = mq.size();
        check("valid",      32'(o_valid),         32'(n != 0));
        check("full",       32'(o_full),          32'(n == 16));
        check("almost",     32'(o_almost_full),   32'(n >= 14));
        check("count",      32'(o_count),         32'(n));
        check("data",       32'(o_data_out),      (n != 0) ? 32'(mq[0]) : 32'h0);
        check("pkt_avail",  32'(o_pkt_avail),     32'(m_pkts != 0));
        check("ovf_err",    32'(o_overflow_err),  32'(m_ovf));
        check("udf_err",    32'(o_underflow_err), 32'(m_udf));
        check("soft_rst",   32'(o_soft_rst),      32'(m_soft));
    endtask

    task automatic model_step(input bit wr, input logic [7:0] d, input bit rd, input bit clr);
        int  n;
        bit  full, valid, flush, rd_ok, wr_ok, wc, rc;
        logic [7:0] b;
        n     = mq.size();
        full  = (n == 16);
        valid = (n != 0);
        flush = valid && !rd && (m_stall == 29);
        rd_ok = rd && valid;
        wr_ok = wr && !full && !flush;
        if (wr && full) m_ovf = 1; else if (clr && !m_clr_q) m_ovf = 0;
        if (rd && !valid) m_udf = 1; else if (clr && !m_clr_q) m_udf = 0;
        m_clr_q = clr;
        m_soft  = flush;
        if (flush) begin
            mq.delete();
            m_wr_left = 0; m_rd_left = 0; m_pkts = 0; m_stall = 0;
        end else begin
            wc = 0; rc = 0;
            if (wr) begin
                if (m_wr_left == 0) begin
                    m_wr_left = int'(d) / 8;
                    wc = (m_wr_left == 0);
                end else begin
                    m_wr_left--;
                    wc = (m_wr_left == 0);
                end
            end
            if (rd_ok) begin
                b = mq.pop_front();
                if (m_rd_left == 0) begin
                    m_rd_left = int'(b) / 8;
                    rc = (m_rd_left == 0);
                end else begin
                    m_rd_left--;
                    rc = (m_rd_left == 0);
                end
            end
            if (wr_ok) mq.push_back(d);
            if (wc && !rc && m_pkts < 16) m_pkts++;
            else if (rc && !wc && m_pkts > 0) m_pkts--;
            m_stall = (!valid || rd_ok) ? 0 : m_stall + 1;
        end
    endtask

    // One clock cycle: drive, compare registered state mid-cycle, advance model.
    task automatic cyc(input bit wr, input logic [7:0] d, input bit rd, input bit clr);
        i_wr_en = wr; i_data_in = d; i_rd_en = rd; i_clr_errors = clr;
        @(negedge i_clk);
        check_outputs();
        model_step(wr, d, rd, clr);
        @(posedge i_clk);
        #1;
    endtask

    task automatic do_reset();
        i_wr_en = 0; i_data_in = 8'h00; i_rd_en = 0; i_clr_errors = 0;
        #2;
        i_rstn = 1'b0;
        #1;
        model_reset();
        check("rst_valid", 32'(o_valid), 32'h0);
        check("rst_count", 32'(o_count), 32'h0);
        check("rst_data",  32'(o_data_out), 32'h0);
        check("rst_pkt",   32'(o_pkt_avail), 32'h0);
        check("rst_errs",  32'({o_overflow_err, o_underflow_err, o_soft_rst, o_full, o_almost_full}), 32'h0);
        @(negedge i_clk);
        i_rstn = 1'b1;
        @(posedge i_clk);
        #1;
    endtask

    function automatic logic [7:0] rnd_byte();
        return ($urandom_range(0, 9) < 7) ? 8'($urandom_range(0, 31)) : 8'($urandom_range(0, 255));
    endfunction

    initial begin
        int v_at, s_at, pulses;
        i_rstn = 1'b1;
        i_wr_en = 0; i_data_in = 0; i_rd_en = 0; i_clr_errors = 0;
        @(posedge i_clk); #1;
        do_reset();

        // Basic 4-byte packet
        cyc(1, 8'h18, 0, 0); cyc(1, 8'hA1, 0, 0); cyc(1, 8'hA2, 0, 0); cyc(1, 8'h19, 0, 0);
        check("basic_pkt_avail", 32'(o_pkt_avail), 32'h1);
        check("basic_head", 32'(o_data_out), 32'h18);
        for (int i = 0; i < 4; i++) cyc(0, 8'h00, 1, 0);
        check("basic_empty", 32'({o_pkt_avail, o_valid, o_count}), 32'h0);

        // Fill to full plus one dropped byte, then clear the error
        do_reset();
        for (int i = 0; i < 16; i++) cyc(1, 8'(8'h40 + i), 0, 0);
        cyc(1, 8'hEE, 0, 0);
        check("fill_full", 32'({o_full, o_count}), 32'h30);
        check("fill_ovf",  32'(o_overflow_err), 32'h1);
        cyc(0, 8'h00, 0, 1); cyc(0, 8'h00, 0, 0);
        check("fill_ovf_clr", 32'(o_overflow_err), 32'h0);
        for (int i = 0; i < 16; i++) cyc(0, 8'h00, 1, 0);

        // Wrap-around
        do_reset();
        for (int i = 0; i < 12; i++) cyc(1, rnd_byte(), 0, 0);
        for (int i = 0; i < 12; i++) cyc(0, 8'h00, 1, 0);
        for (int i = 0; i < 10; i++) cyc(1, rnd_byte(), 0, 0);
        check("wrap_count", 32'(o_count), 32'd10);
        for (int i = 0; i < 10; i++) cyc(0, 8'h00, 1, 0);

        // Simultaneous read/write at count 5, then read while empty
        for (int i = 0; i < 5; i++) cyc(1, rnd_byte(), 0, 0);
        for (int i = 0; i < 8; i++) cyc(1, rnd_byte(), 1, 0);
        check("rw_count", 32'(o_count), 32'd5);
        for (int i = 0; i < 5; i++) cyc(0, 8'h00, 1, 0);
        cyc(0, 8'h00, 1, 0);
        check("udf_set", 32'(o_underflow_err), 32'h1);
        cyc(0, 8'h00, 0, 1); cyc(0, 8'h00, 0, 0);

        // Timeout flush with a 2-byte packet never read
        do_reset();
        v_at = -1; s_at = -1; pulses = 0;
        for (int i = 0; i < 45; i++) begin
            if (i == 0)      cyc(1, 8'h08, 0, 0);
            else if (i == 1) cyc(1, 8'h5A, 0, 0);
            else             cyc(0, 8'h00, 0, 0);
            if (o_valid && v_at < 0) v_at = i;
            if (o_soft_rst) begin pulses++; s_at = i; end
        end
        check("to_pulses", 32'(pulses), 32'd1);
        check("to_delay",  32'(s_at - v_at), 32'd30);
        check("to_empty",  32'({o_valid, o_count, o_pkt_avail}), 32'h0);

        // Reset mid-packet, then a fresh packet
        cyc(1, 8'h18, 0, 0); cyc(1, 8'hA1, 0, 0);
        do_reset();
        cyc(1, 8'h10, 0, 0); cyc(1, 8'hB1, 0, 0);
        check("fresh_partial", 32'(o_pkt_avail), 32'h0);
        cyc(1, 8'hB2, 0, 0);
        check("fresh_pkt", 32'(o_pkt_avail), 32'h1);
        for (int i = 0; i < 3; i++) cyc(0, 8'h00, 1, 0);
        check("fresh_done", 32'(o_pkt_avail), 32'h0);

        // Random traffic with periodic consumer stalls
        do_reset();
        for (int i = 0; i < 1500; i++) begin
            if ((i % 300) >= 260)
                cyc($urandom_range(0, 3) == 0, rnd_byte(), 0, 0);
            else
                cyc($urandom_range(0, 9) < 6, rnd_byte(), $urandom_range(0, 9) < 5,
                    $urandom_range(0, 19) == 0);
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
